// File: rtl/spi_regslave_pkg.sv
// spi_regslave_pkg
//   Shared constants and helpers for the SPI register slave.
//   SYNC_STAGES : depth of the input synchronisers
//   READ_FILL   : value shifted into the MISO shifter behind valid data
//   clog2()     : ceiling log2, usable in parameter expressions
//   bitcnt_width() / sel_width() : derived widths for the top level
package spi_regslave_pkg;

  localparam int   SYNC_STAGES = 2;
  localparam logic READ_FILL   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bit counter must hold 0..RW+1 (RW+1 marks "too long").
  function automatic int bitcnt_width(input int rw);
    return clog2(rw + 2);
  endfunction

  // A single-register bank still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  localparam int RW_DEFAULT       = 40;
  localparam int BITCNT_W_DEFAULT = bitcnt_width(RW_DEFAULT);

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Brings one asynchronous SPI pin into the fclk domain.
//   fclk    : system clock
//   rst_n   : asynchronous active-low reset
//   din_i   : asynchronous input pin
//   level_o : synchronised level, aligned with the edge pulses
//   rise_o  : one-fclk pulse on a 0->1 transition
//   fall_o  : one-fclk pulse on a 1->0 transition
module spi_sync_edge
  import spi_regslave_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // prev_q doubles as the level output so that level and edge pulses
  // change on the same fclk edge; sdo then lines up with sck_rise.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
      prev_q <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_regslave.sv
// spi_regslave
//   SPI slave holding a bank of NREGS write registers of RW bits each.
//   Address byte is shifted in while spics_n is high, data while it is low;
//   the register commits on the following spics_n rise only if exactly RW
//   bits arrived. A zero-length data phase is a command strobe.
//   fclk, rst_n          : clock, async active-low reset
//   spics_n/spick/spido  : AVR SPI inputs (asynchronous)
//   spidi                : AVR MISO
//   status_in            : byte returned during the address phase
//   rd_sel / rd_data     : read-back mux select and word
//   wr_data              : flattened register contents
//   wr_stb/cmd_stb/err_stb : one-fclk event strobes
module spi_regslave
  import spi_regslave_pkg::*;
#(
  parameter int             NREGS   = 8,
  parameter int             RW      = 40,
  parameter logic [7:0]     BASE    = 8'h10,
  parameter logic [RW-1:0]  RST_VAL = '0,
  localparam int            SEL_W   = sel_width(NREGS)
) (
  input  logic                fclk,
  input  logic                rst_n,
  input  logic                spics_n,
  input  logic                spick,
  input  logic                spido,
  output logic                spidi,
  input  logic [7:0]          status_in,
  output logic [SEL_W-1:0]    rd_sel,
  input  logic [RW-1:0]       rd_data,
  output logic [NREGS*RW-1:0] wr_data,
  output logic [NREGS-1:0]    wr_stb,
  output logic [NREGS-1:0]    cmd_stb,
  output logic                err_stb
);

  localparam int BC_W = bitcnt_width(RW);
  localparam logic [8:0] HIT_LO = {1'b0, BASE};
  localparam logic [8:0] HIT_HI = HIT_LO + 9'(NREGS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_rise, sck_lvl_unused, sck_fall_unused;
  logic sdo_lvl, sdo_rise_unused, sdo_fall_unused;

  spi_sync_edge #(.INIT(1'b1)) u_sync_cs (
    .fclk(fclk), .rst_n(rst_n), .din_i(spics_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.INIT(1'b0)) u_sync_sck (
    .fclk(fclk), .rst_n(rst_n), .din_i(spick),
    .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall_unused)
  );

  spi_sync_edge #(.INIT(1'b0)) u_sync_sdo (
    .fclk(fclk), .rst_n(rst_n), .din_i(spido),
    .level_o(sdo_lvl), .rise_o(sdo_rise_unused), .fall_o(sdo_fall_unused)
  );

  logic [7:0]          regnum_q, regnum_d;
  logic [RW-1:0]       shadow_q, shadow_d;
  logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
  logic [RW-1:0]       out_q, out_d;
  logic [NREGS*RW-1:0] regs_q, regs_d;
  logic [NREGS-1:0]    wr_stb_q, wr_stb_d;
  logic [NREGS-1:0]    cmd_stb_q, cmd_stb_d;
  logic                err_stb_q, err_stb_d;

  logic             hit;
  logic [SEL_W-1:0] idx;

  // Compared in 9 bits so BASE+NREGS past 8'hFF cannot wrap into a hit.
  assign hit = ({1'b0, regnum_q} >= HIT_LO) && ({1'b0, regnum_q} < HIT_HI);
  assign idx = SEL_W'(regnum_q - BASE);

  always_comb begin
    regnum_d  = regnum_q;
    shadow_d  = shadow_q;
    bitcnt_d  = bitcnt_q;
    out_d     = out_q;
    regs_d    = regs_q;
    wr_stb_d  = '0;
    cmd_stb_d = '0;
    err_stb_d = 1'b0;

    // cs edges take priority; an sck_rise in the same cycle is dropped.
    if (cs_rise) begin
      regnum_d   = '0;
      out_d      = {RW{READ_FILL}};
      out_d[7:0] = status_in;
      if (hit) begin
        if (bitcnt_q == BC_W'(RW)) begin
          regs_d[idx*RW +: RW] = shadow_q;
          wr_stb_d[idx]        = 1'b1;
        end else if (bitcnt_q == '0) begin
          cmd_stb_d[idx] = 1'b1;
        end else begin
          err_stb_d = 1'b1;
        end
      end
    end else if (cs_fall) begin
      bitcnt_d = '0;
      out_d    = hit ? rd_data : {RW{READ_FILL}};
    end else if (sck_rise) begin
      out_d = {READ_FILL, out_q[RW-1:1]};
      if (cs_lvl) begin
        regnum_d = {sdo_lvl, regnum_q[7:1]};
      end else begin
        shadow_d = {sdo_lvl, shadow_q[RW-1:1]};
        // Saturating at RW+1 keeps any over-length transfer distinguishable.
        if (bitcnt_q != BC_W'(RW + 1)) begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      regnum_q  <= '0;
      shadow_q  <= '0;
      bitcnt_q  <= '0;
      out_q     <= {RW{READ_FILL}};
      regs_q    <= {NREGS{RST_VAL}};
      wr_stb_q  <= '0;
      cmd_stb_q <= '0;
      err_stb_q <= 1'b0;
    end else begin
      regnum_q  <= regnum_d;
      shadow_q  <= shadow_d;
      bitcnt_q  <= bitcnt_d;
      out_q     <= out_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      cmd_stb_q <= cmd_stb_d;
      err_stb_q <= err_stb_d;
    end
  end

  assign spidi   = out_q[0];
  assign rd_sel  = hit ? idx : '0;
  assign wr_data = regs_q;
  assign wr_stb  = wr_stb_q;
  assign cmd_stb = cmd_stb_q;
  assign err_stb = err_stb_q;

endmodule

// File: tb/tb_spi_regslave.sv
module tb_spi_regslave;

  localparam int NREGS = 8;
  localparam int RW    = 40;

  logic              fclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spics_n = 1'b1;
  logic              spick = 1'b0;
  logic              spido = 1'b0;
  logic              spidi;
  logic [7:0]        status_in = 8'hC3;
  logic [2:0]        rd_sel;
  logic [RW-1:0]     rd_data = '0;
  logic [NREGS*RW-1:0] wr_data;
  logic [NREGS-1:0]  wr_stb;
  logic [NREGS-1:0]  cmd_stb;
  logic              err_stb;

  spi_regslave #(.NREGS(NREGS), .RW(RW), .BASE(8'h10), .RST_VAL('0)) dut (
    .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick), .spido(spido),
    .spidi(spidi), .status_in(status_in), .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_data(wr_data), .wr_stb(wr_stb), .cmd_stb(cmd_stb), .err_stb(err_stb)
  );

  always #5 fclk = ~fclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe scoreboard entries: {wr_stb, cmd_stb, err_stb}.
  logic [16:0] exp_q[$];
  logic [RW-1:0] model_regs [NREGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge fclk) begin
    logic [16:0] ev;
    logic [16:0] e;
    ev = {wr_stb, cmd_stb, err_stb};
    if (rst_n && ev != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(ev), 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("strobe", 64'(ev), 64'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic shift_bits(input logic [63:0] mosi, input int n, output logic [63:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      spido = mosi[i];
      tick(4);
      miso[i] = spidi;
      spick = 1'b1;
      tick(4);
      spick = 1'b0;
    end
  endtask

  function automatic logic [63:0] exp_miso(input logic hit, input logic [RW-1:0] rd, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[i] = (hit && i < RW) ? rd[i] : 1'b1;
    return r;
  endfunction

  task automatic check_regs(input string name);
    for (int i = 0; i < NREGS; i++)
      check(name, 64'(wr_data[i*RW +: RW]), 64'(model_regs[i]));
  endtask

  typedef struct {
    logic [7:0]  addr;
    int          nbits;
    logic [63:0] data;
    logic [RW-1:0] rd;
    logic [7:0]  status;
    logic [7:0]  exp_wr;
    logic [7:0]  exp_cmd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [63:0] miso;
    logic [7:0]  prev_status;
    logic        hit;

    vecs[0] = '{8'h12, 40, 64'h00A5A55A5A,   40'h0,          8'hC3, 8'h04, 8'h00, 1'b0};
    vecs[1] = '{8'h13, 39, 64'h12345678,     40'h0,          8'h3C, 8'h00, 8'h00, 1'b1};
    vecs[2] = '{8'h15, 0,  64'h0,            40'h0,          8'hC3, 8'h00, 8'h20, 1'b0};
    vecs[3] = '{8'h11, 48, 64'hFFFFFFFFFFFF, 40'h0102030405, 8'hC3, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'h30, 40, 64'h1122334455,   40'h0102030405, 8'h5A, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h17, 40, 64'hDEADBEEF01,   40'hCAFE000001, 8'hA5, 8'h80, 8'h00, 1'b0};
    vecs[6] = '{8'h18, 40, 64'hFFFFFFFFFF,   40'h0,          8'h81, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'h0F, 40, 64'hFFFFFFFFFF,   40'h0,          8'h18, 8'h00, 8'h00, 1'b0};
    vecs[8] = '{8'h10, 41, 64'h1FFFFFFFFFF,  40'h123456789A, 8'hC3, 8'h00, 8'h00, 1'b1};
    vecs[9] = '{8'h12, 40, 64'h1122334455,   40'h00A5A55A5A, 8'hC3, 8'h04, 8'h00, 1'b0};

    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;

    tick(3);
    rst_n = 1'b1;
    tick(4);

    check("reset_spidi", 64'(spidi), 64'h1);
    check("reset_strobes", 64'({wr_stb, cmd_stb, err_stb}), 64'h0);
    check("reset_rd_sel", 64'(rd_sel), 64'h0);
    check_regs("reset_regs");

    prev_status = 8'hFF;
    for (int v = 0; v < 10; v++) begin
      hit = (vecs[v].addr >= 8'h10) && (vecs[v].addr < 8'h18);
      shift_bits(64'(vecs[v].addr), 8, miso);
      check("addr_phase_miso", miso, 64'(prev_status));
      check("rd_sel", 64'(rd_sel), hit ? 64'(vecs[v].addr - 8'h10) : 64'h0);
      rd_data = vecs[v].rd;
      spics_n = 1'b0;
      tick(8);
      shift_bits(vecs[v].data, vecs[v].nbits, miso);
      if (vecs[v].nbits > 0)
        check("data_phase_miso", miso, exp_miso(hit, vecs[v].rd, vecs[v].nbits));
      if (vecs[v].exp_wr != '0 || vecs[v].exp_cmd != '0 || vecs[v].exp_err)
        exp_q.push_back({vecs[v].exp_wr, vecs[v].exp_cmd, vecs[v].exp_err});
      if (vecs[v].exp_wr != '0)
        model_regs[vecs[v].addr - 8'h10] = vecs[v].data[RW-1:0];
      status_in = vecs[v].status;
      spics_n = 1'b1;
      tick(8);
      prev_status = vecs[v].status;
      check_regs("regs_after_vec");
    end

    // Commit latency: strobe appears on the 4th fclk edge after spics_n rises.
    shift_bits(64'h14, 8, miso);
    spics_n = 1'b0;
    tick(8);
    shift_bits(64'h0F0E0D0C0B, 40, miso);
    exp_q.push_back({8'h10, 8'h00, 1'b0});
    model_regs[4] = 40'h0F0E0D0C0B;
    spics_n = 1'b1;
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    check("latency_edge3", 64'(wr_stb), 64'h0);
    @(posedge fclk);
    @(negedge fclk);
    check("latency_edge4", 64'(wr_stb), 64'h10);
    tick(8);
    check_regs("regs_after_latency");

    // Reset in the middle of a data phase throws the partial transfer away.
    shift_bits(64'h10, 8, miso);
    spics_n = 1'b0;
    tick(8);
    shift_bits(64'h1FFFF, 17, miso);
    rst_n = 1'b0;
    tick(2);
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
    check("midreset_spidi", 64'(spidi), 64'h1);
    rst_n = 1'b1;
    tick(8);
    spics_n = 1'b1;
    tick(8);
    check_regs("regs_after_midreset");
    shift_bits(64'h10, 8, miso);
    spics_n = 1'b0;
    tick(8);
    shift_bits(64'h8877665544, 40, miso);
    exp_q.push_back({8'h01, 8'h00, 1'b0});
    model_regs[0] = 40'h8877665544;
    spics_n = 1'b1;
    tick(10);
    check_regs("regs_after_rewrite");

    tick(10);
    check("missing_strobes", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
